// File: rtl/gcd_pkg.sv
// Shared constants and helpers for the GCD unit and its operand-pair queue.
package gcd_pkg;

    localparam int GCD_WL_DEFAULT     = 8;
    localparam int GCD_QDEPTH_DEFAULT = 4;

    // One extra bit above the storage index serves as the wrap flag.
    function automatic int gcd_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gcd_ops_mem.sv
// Operand-pair storage: DEPTH entries of {A, B}, synchronous write, asynchronous read.
module gcd_ops_mem
    import gcd_pkg::*;
#(
    parameter int WL    = GCD_WL_DEFAULT,
    parameter int DEPTH = GCD_QDEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [2*WL-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [2*WL-1:0]            rdata
);

    logic [2*WL-1:0] mem [DEPTH];

    // Contents are never reset; the queue pointers alone define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gcd_ops_queue.sv
// In-order (A, B) operand-pair queue feeding the GCD unit's ops_val/ops_rdy handshake.
module gcd_ops_queue
    import gcd_pkg::*;
#(
    parameter int WL    = GCD_WL_DEFAULT,
    parameter int DEPTH = GCD_QDEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       flush,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [WL-1:0]              in_A,
    input  logic [WL-1:0]              in_B,
    output logic                       ops_val,
    input  logic                       ops_rdy,
    output logic [WL-1:0]              ops_A,
    output logic [WL-1:0]              ops_B,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = gcd_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [2*WL-1:0] rd_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    assign in_rdy  = !full;
    assign ops_val = !empty;
    assign count   = wr_ptr - rd_ptr;

    // A flush in the same cycle discards the push and cancels the pop.
    assign push = in_val && in_rdy && !flush;
    assign pop  = ops_val && ops_rdy && !flush;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    gcd_ops_mem #(
        .WL    (WL),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({in_A, in_B}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign ops_A = rd_data[2*WL-1:WL];
    assign ops_B = rd_data[WL-1:0];

endmodule

// File: tb/tb_gcd_ops_queue.sv
// Bench for gcd_ops_queue: directed scenarios plus random traffic against a queue-based reference.
module tb_gcd_ops_queue;

    localparam int WL    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          flush = 1'b0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [WL-1:0] in_A = '0;
    logic [WL-1:0] in_B = '0;
    logic          ops_val;
    logic          ops_rdy = 1'b0;
    logic [WL-1:0] ops_A;
    logic [WL-1:0] ops_B;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    // Reference: the queued pairs, oldest first.
    logic [2*WL-1:0] mq [$];

    gcd_ops_queue #(.WL(WL), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .flush   (flush),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_A    (in_A),
        .in_B    (in_B),
        .ops_val (ops_val),
        .ops_rdy (ops_rdy),
        .ops_A   (ops_A),
        .ops_B   (ops_B),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference across the edge, sample 1 time unit later.
    task automatic tick(input logic v, input logic [WL-1:0] a, input logic [WL-1:0] b,
                        input logic r, input logic f);
        bit acc;
        bit pp;
        in_val = v; in_A = a; in_B = b; ops_rdy = r; flush = f;
        acc = v && (mq.size() < DEPTH);
        pp  = r && (mq.size() > 0);
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back({a, b});
        end
        #1;
        in_val = 1'b0; ops_rdy = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (in_rdy !== 1'b1 || ops_val !== 1'b0 || count !== CW'(0)) begin
            failures++;
            $display("FAIL reset_outputs: in_rdy=%b ops_val=%b count=%0d, want 1 0 0", in_rdy, ops_val, count);
        end
        @(negedge clk);
        rst_b = 1'b1;
        mq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        tick(1'b1, 8'd6, 8'd4, 1'b0, 1'b0);
        checks++;
        if (ops_val !== 1'b1 || ops_A !== 8'd6 || ops_B !== 8'd4 || count !== CW'(1)) begin
            failures++;
            $display("FAIL single_push: val=%b A=%0d B=%0d count=%0d, want 1 6 4 1", ops_val, ops_A, ops_B, count);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
            checks++;
            if (ops_val !== 1'b1 || ops_A !== 8'd6 || ops_B !== 8'd4) begin
                failures++;
                $display("FAIL single_hold[%0d]: val=%b A=%0d B=%0d, want 1 6 4", i, ops_val, ops_A, ops_B);
            end
        end
        tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        checks++;
        if (ops_val !== 1'b0 || count !== CW'(0)) begin
            failures++;
            $display("FAIL single_pop: val=%b count=%0d, want 0 0", ops_val, count);
        end
    endtask

    task automatic test_fill();
        logic [2*WL-1:0] exp [4];
        exp[0] = {8'd6, 8'd4}; exp[1] = {8'd6, 8'd8}; exp[2] = {8'd9, 8'd3}; exp[3] = {8'd0, 8'd5};
        for (int i = 0; i < 4; i++) tick(1'b1, exp[i][15:8], exp[i][7:0], 1'b0, 1'b0);
        checks++;
        if (in_rdy !== 1'b0 || count !== CW'(4)) begin
            failures++;
            $display("FAIL fill_full: in_rdy=%b count=%0d, want 0 4", in_rdy, count);
        end
        tick(1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(4) || {ops_A, ops_B} !== exp[0]) begin
            failures++;
            $display("FAIL fill_refuse: count=%0d head=%h, want 4 %h", count, {ops_A, ops_B}, exp[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ops_val !== 1'b1 || {ops_A, ops_B} !== exp[i]) begin
                failures++;
                $display("FAIL fill_order[%0d]: val=%b head=%h, want 1 %h", i, ops_val, {ops_A, ops_B}, exp[i]);
            end
            tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        end
        checks++;
        if (count !== CW'(0) || ops_val !== 1'b0) begin
            failures++;
            $display("FAIL fill_drain: count=%0d val=%b, want 0 0", count, ops_val);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 8'd1, 8'd2, 1'b0, 1'b0);
        tick(1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
        for (int k = 3; k < 9; k++) begin
            tick(1'b1, WL'(k), WL'(k + 1), 1'b1, 1'b0);
            checks++;
            if (count !== CW'(2) || ops_A !== WL'(k - 1) || ops_B !== WL'(k)) begin
                failures++;
                $display("FAIL b2b[%0d]: count=%0d A=%0d B=%0d, want 2 %0d %0d", k, count, ops_A, ops_B, k - 1, k);
            end
        end
        tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        checks++;
        if (ops_A !== 8'd8 || ops_B !== 8'd9 || count !== CW'(1)) begin
            failures++;
            $display("FAIL b2b_tail: A=%0d B=%0d count=%0d, want 8 9 1", ops_A, ops_B, count);
        end
        tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_full_pop_push();
        for (int i = 0; i < 4; i++) tick(1'b1, WL'(10 + i), WL'(20 + i), 1'b0, 1'b0);
        tick(1'b1, 8'd50, 8'd51, 1'b1, 1'b0);
        checks++;
        if (count !== CW'(3) || in_rdy !== 1'b1 || ops_A !== 8'd11) begin
            failures++;
            $display("FAIL full_pop: count=%0d in_rdy=%b A=%0d, want 3 1 11", count, in_rdy, ops_A);
        end
        tick(1'b1, 8'd50, 8'd51, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(4) || in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL full_repush: count=%0d in_rdy=%b, want 4 0", count, in_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ops_A, ops_B} !== ((i < 3) ? {WL'(11 + i), WL'(21 + i)} : {8'd50, 8'd51})) begin
                failures++;
                $display("FAIL full_order[%0d]: head=%h", i, {ops_A, ops_B});
            end
            tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) tick(1'b1, WL'(30 + i), WL'(40 + i), 1'b0, 1'b0);
        tick(1'b1, 8'd1, 8'd2, 1'b1, 1'b1);
        checks++;
        if (count !== CW'(0) || ops_val !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: count=%0d val=%b in_rdy=%b, want 0 0 1", count, ops_val, in_rdy);
        end
        tick(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        checks++;
        if (ops_val !== 1'b0) begin
            failures++;
            $display("FAIL flush_stale: val=%b A=%0d B=%0d, want val 0", ops_val, ops_A, ops_B);
        end
        tick(1'b1, 8'd3, 8'd3, 1'b0, 1'b0);
        checks++;
        if (ops_A !== 8'd3 || ops_B !== 8'd3 || count !== CW'(1)) begin
            failures++;
            $display("FAIL flush_next: A=%0d B=%0d count=%0d, want 3 3 1", ops_A, ops_B, count);
        end
        tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        tick(1'b1, 8'd5, 8'd6, 1'b0, 1'b0);
        tick(1'b1, 8'd7, 8'd8, 1'b0, 1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        checks++;
        if (ops_val !== 1'b0 || in_rdy !== 1'b1 || count !== CW'(0)) begin
            failures++;
            $display("FAIL async_reset: val=%b in_rdy=%b count=%0d, want 0 1 0", ops_val, in_rdy, count);
        end
        #1;
        rst_b = 1'b1;
        mq.delete();
        tick(1'b1, 8'd12, 8'd18, 1'b0, 1'b0);
        checks++;
        if (ops_A !== 8'd12 || ops_B !== 8'd18 || count !== CW'(1)) begin
            failures++;
            $display("FAIL async_after: A=%0d B=%0d count=%0d, want 12 18 1", ops_A, ops_B, count);
        end
        tick(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 2) != 0), WL'($urandom), WL'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
            checks++;
            if (int'(count) != mq.size() || ops_val !== (mq.size() != 0) || in_rdy !== (mq.size() < DEPTH)
                || (mq.size() != 0 && {ops_A, ops_B} !== mq[0])) begin
                failures++;
                $display("FAIL random[%0d]: count=%0d val=%b rdy=%b head=%h, want count=%0d head=%h",
                         i, count, ops_val, in_rdy, {ops_A, ops_B}, mq.size(),
                         (mq.size() != 0) ? mq[0] : 16'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
